nibble_swap_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `NibbleSwapper` datapath (8-bit input, `swap_en`, 8-bit output) between `N_REQ` requesters. Each requester presents a byte and a per-transfer swap flag over a valid/ready handshake. The winner's byte goes through the shared swapper and lands in a registered output stage tagged with the requester ID. The block sits between producer channels and a single downstream consumer.

---
 rtl/nibble_swap_arbiter.sv | 96 +++++++++
 tb/tb_nibble_swap_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_swap_arbiter.sv
// Round-robin arbiter that shares one nibble swapper between N_REQ requesters and registers the result.
// Optional transfer counter port xfer_count is built when NIBBLE_SWAP_ARB_STATS_EN is defined.
module nibble_swap_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_swap,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic [ID_W-1:0]    out_id,
`ifdef NIBBLE_SWAP_ARB_STATS_EN
    output logic [15:0]        xfer_count,
`endif
    input  logic               out_ready
);

    logic [ID_W-1:0]  last_grant_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic [ID_W-1:0]  out_id_q;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             found;
    logic             load;
    logic             xfer;
    logic [7:0]       sel_data;
    logic             sel_swap;
    logic [7:0]       swap_out;

    // Search starts one past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

    assign load      = !out_valid_q || out_ready;
    assign xfer      = found && load && !rst;
    assign req_ready = xfer ? grant : '0;

    // Shared swapper datapath fed by the granted requester.
    assign sel_data = req_data[32'(grant_idx)*8 +: 8];
    assign sel_swap = req_swap[grant_idx];
    assign swap_out = sel_swap ? {sel_data[3:0], sel_data[7:4]} : sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else if (xfer) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= swap_out;
            out_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef NIBBLE_SWAP_ARB_STATS_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= 16'h0000;
        end else if (out_valid_q && out_ready) begin
            xfer_count_q <= xfer_count_q + 16'h0001;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_nibble_swap_arbiter.sv
// Bench for nibble_swap_arbiter: directed scenarios plus random traffic against a queue-free
// behavioural model of the round-robin rule and output register.
module tb_nibble_swap_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_swap;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [1:0]    out_id;
    logic          out_ready;
`ifdef NIBBLE_SWAP_ARB_STATS_EN
    logic [15:0]   xfer_count;
`endif

    nibble_swap_arbiter #(
        .N_REQ(N),
        .ID_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_swap  (req_swap),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
`ifdef NIBBLE_SWAP_ARB_STATS_EN
        .xfer_count(xfer_count),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Reference model state
    logic          m_valid;
    logic [7:0]    m_data;
    logic [1:0]    m_id;
    int            m_lg;
    logic [15:0]   m_cnt;
    logic [N-1:0]  obs_rdy;
    logic [N-1:0]  last_acc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check req_ready before the edge, advance the model, check outputs after the edge.
    task automatic step(input string tag);
        logic [N-1:0] exp_rdy;
        logic [7:0]   b;
        int           g;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && req_valid[(m_lg + k) % N]) g = (m_lg + k) % N;
        end
        exp_rdy = '0;
        if (g >= 0 && (!m_valid || out_ready) && !rst) exp_rdy[g] = 1'b1;
        obs_rdy = req_ready;
        chk({tag, "/ready"}, 16'(req_ready), 16'(exp_rdy));
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_id = 2'd0; m_lg = N - 1; m_cnt = 16'h0;
        end else begin
            if (m_valid && out_ready) m_cnt = m_cnt + 16'h1;
            if (exp_rdy != '0) begin
                b       = req_data[8*g +: 8];
                m_data  = req_swap[g] ? {b[3:0], b[7:4]} : b;
                m_valid = 1'b1;
                m_id    = 2'(g);
                m_lg    = g;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        last_acc = exp_rdy;
        @(posedge clk);
        #1;
        chk({tag, "/out_valid"}, 16'(out_valid), 16'(m_valid));
        chk({tag, "/out_data"}, 16'(out_data), 16'(m_data));
        chk({tag, "/out_id"}, 16'(out_id), 16'(m_id));
`ifdef NIBBLE_SWAP_ARB_STATS_EN
        chk({tag, "/xfer_count"}, xfer_count, m_cnt);
`endif
    endtask

    logic [7:0] fair_d [4];
    logic [1:0] fair_id [6];

    initial begin
        fair_d  = '{8'h01, 8'h12, 8'h23, 8'h34};
        fair_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        m_valid = 1'b0; m_data = 8'h00; m_id = 2'd0; m_lg = N - 1; m_cnt = 16'h0;
        req_valid = '0; req_data = '0; req_swap = '0; out_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        step("reset");
        chk("reset_valid", 16'(out_valid), 16'h0);
        chk("reset_data", 16'(out_data), 16'h0);
        rst = 1'b0;

        // Pass and swap
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_swap = 4'b0001;
        step("swap");
        chk("swap_ready", 16'(obs_rdy), 16'h1);
        chk("swap_data", 16'(out_data), 16'h5A);
        chk("swap_id", 16'(out_id), 16'h0);
        req_data[7:0] = 8'h12; req_swap = 4'b0000;
        step("pass");
        chk("pass_data", 16'(out_data), 16'h12);
        req_valid = '0;
        step("drain");

        // Fairness from a fresh pointer
        rst = 1'b1;
        step("rst2");
        rst = 1'b0;
        req_valid = 4'b1111; req_data = 32'h43322110; req_swap = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            step("fair");
            chk("fair_id", 16'(out_id), 16'(fair_id[j]));
            chk("fair_data", 16'(out_data), 16'(fair_d[j % 4]));
            chk("fair_valid", 16'(out_valid), 16'h1);
        end

        // Backpressure: hold 0x12/id 2 while requester 3 waits
        req_valid = 4'b0100; req_data[23:16] = 8'h21; req_swap = 4'b1100;
        step("bp_load");
        chk("bp_load_data", 16'(out_data), 16'h12);
        req_valid = 4'b1000; req_data[31:24] = 8'h9C; out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step("bp_hold");
            chk("bp_ready", 16'(obs_rdy), 16'h0);
            chk("bp_data", 16'(out_data), 16'h12);
            chk("bp_id", 16'(out_id), 16'h2);
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp_rel_ready", 16'(obs_rdy), 16'h8);
        chk("bp_rel_data", 16'(out_data), 16'hC9);
        req_valid = '0;

        // Skip idle requesters
        req_valid = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            step("skip");
            chk("skip_ready", 16'(obs_rdy), (j % 2 == 0) ? 16'h2 : 16'h8);
        end

        // Reset under backpressure
        req_valid = 4'b0100; out_ready = 1'b0;
        step("mr_load");
        step("mr_hold");
        rst = 1'b1; req_valid = 4'b1100;
        step("mr_rst");
        chk("mr_rst_ready", 16'(obs_rdy), 16'h0);
        chk("mr_valid", 16'(out_valid), 16'h0);
        chk("mr_data", 16'(out_data), 16'h0);
        rst = 1'b0;
        step("mr_first");
        chk("mr_first_ready", 16'(obs_rdy), 16'h4);
        req_valid = '0; out_ready = 1'b1;
        step("mr_drain");

        // Random traffic; producers hold requests until accepted
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < N; i++) begin
                if (last_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_swap[i]        = 1'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            step("rand");
        end
        rst = 1'b0;

`ifdef NIBBLE_SWAP_ARB_STATS_EN
        // Counter wrap: 65537 accepted outputs after reset
        rst = 1'b1; req_valid = '0; out_ready = 1'b1;
        step("st_rst");
        rst = 1'b0;
        req_valid = 4'b0001;
        repeat (65538) @(posedge clk);
        #1;
        chk("stats_wrap", xfer_count, 16'h0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
